// File: rtl/ring_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ring_pkg
// Description : Shared constants and home-state helper for the ring/Johnson
//               sequencer family.
// Revision    : 1.0 - initial release
// ============================================================================
package ring_pkg;

    localparam logic MODE_RING    = 1'b0;
    localparam logic MODE_JOHNSON = 1'b1;
    localparam logic DIR_UP       = 1'b0;
    localparam logic DIR_DOWN     = 1'b1;

    // Widest counter the home-state helper can describe.
    localparam int MAX_WIDTH = 64;

    // The caller truncates the result to its own WIDTH.
    function automatic logic [MAX_WIDTH-1:0] home_state(
        input logic                 mode,
        input logic [MAX_WIDTH-1:0] ring_seed
    );
        return (mode == MODE_JOHNSON) ? '0 : ring_seed;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ring_legal_chk.sv
`default_nettype none
// ============================================================================
// Module      : ring_legal_chk
// Description : Combinational legality check of a ring (one-hot) or Johnson
//               (thermometer) counter state.
// Revision    : 1.0 - initial release
// ============================================================================
module ring_legal_chk
    import ring_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] count,
    input  logic             mode,
    output logic             legal
);

    logic [WIDTH-2:0] w_diff;
    logic             w_ring_ok;
    logic             w_johnson_ok;

    // Each set bit of w_diff marks a boundary between adjacent unequal bits.
    assign w_diff       = count[WIDTH-2:0] ^ count[WIDTH-1:1];
    assign w_ring_ok    = (count != '0) && ((count & (count - WIDTH'(1))) == '0);
    assign w_johnson_ok = ((w_diff & (w_diff - (WIDTH-1)'(1))) == '0);

    assign legal = (mode == MODE_JOHNSON) ? w_johnson_ok : w_ring_ok;

endmodule
`default_nettype wire

// File: rtl/ring_counter_param.sv
`default_nettype none
// ============================================================================
// Module      : ring_counter_param
// Description : WIDTH-bit ring / Johnson shift counter with direction, enable,
//               parallel load and self-correction of illegal states.
// Revision    : 1.0 - initial release
// ============================================================================
module ring_counter_param
    import ring_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RING_SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             init_n,
    input  logic             mode,
    input  logic             dir,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             err
);

    generate
        if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
            $error("ring_counter_param: WIDTH must be in 2..%0d", MAX_WIDTH);
        end
        if ($countones(RING_SEED) != 1) begin : g_bad_seed
            $error("ring_counter_param: RING_SEED must be one-hot");
        end
    endgenerate

    localparam logic [WIDTH-1:0] c_home_ring =
        WIDTH'(home_state(MODE_RING, MAX_WIDTH'(RING_SEED)));
    localparam logic [WIDTH-1:0] c_home_johnson =
        WIDTH'(home_state(MODE_JOHNSON, MAX_WIDTH'(RING_SEED)));

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_err;

    logic [WIDTH-1:0] w_home;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_next;
    logic             w_legal;
    logic             w_wrap_next;
    logic             w_err_next;

    assign w_home = (mode == MODE_JOHNSON) ? c_home_johnson : c_home_ring;

    ring_legal_chk #(
        .WIDTH (WIDTH)
    ) u_legal_chk (
        .count (r_count),
        .mode  (mode),
        .legal (w_legal)
    );

    always_comb begin
        w_step = r_count;
        case ({mode, dir})
            {MODE_RING,    DIR_UP}:   w_step = {r_count[WIDTH-2:0], r_count[WIDTH-1]};
            {MODE_RING,    DIR_DOWN}: w_step = {r_count[0], r_count[WIDTH-1:1]};
            {MODE_JOHNSON, DIR_UP}:   w_step = {r_count[WIDTH-2:0], ~r_count[WIDTH-1]};
            {MODE_JOHNSON, DIR_DOWN}: w_step = {~r_count[0], r_count[WIDTH-1:1]};
            default:                  w_step = r_count;
        endcase
    end

    // Load bypasses the legality check; correction outranks stepping.
    always_comb begin
        w_next      = r_count;
        w_wrap_next = 1'b0;
        w_err_next  = 1'b0;
        if (load) begin
            w_next = load_val;
        end else if (!w_legal) begin
            w_next     = w_home;
            w_err_next = 1'b1;
        end else if (en) begin
            w_next      = w_step;
            w_wrap_next = (w_step == w_home);
        end
    end

    always_ff @(posedge clk) begin
        if (!init_n) begin
            r_count <= w_home;
            r_wrap  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_count <= w_next;
            r_wrap  <= w_wrap_next;
            r_err   <= w_err_next;
        end
    end

    assign count = r_count;
    assign wrap  = r_wrap;
    assign err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ring_counter_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_ring_counter_param
// Description : Directed self-checking bench for ring_counter_param, WIDTH=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ring_counter_param;

    logic       clk = 1'b0;
    logic       init_n;
    logic       mode;
    logic       dir;
    logic       en;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] count;
    logic       wrap;
    logic       err;

    int passed = 0;
    int total  = 0;

    ring_counter_param #(
        .WIDTH     (4),
        .RING_SEED (4'b0001)
    ) dut (
        .clk      (clk),
        .init_n   (init_n),
        .mode     (mode),
        .dir      (dir),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .wrap     (wrap),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    // One clock edge, then compare all three outputs just after it.
    task automatic step_chk(input string tag, input logic [3:0] ec,
                            input logic ew, input logic ee);
        @(posedge clk);
        #1;
        chk({tag, ".count"}, count, ec);
        chk({tag, ".wrap"}, {3'b0, wrap}, {3'b0, ew});
        chk({tag, ".err"},  {3'b0, err},  {3'b0, ee});
    endtask

    initial begin
        init_n = 1'b0; mode = 1'b0; dir = 1'b0; en = 1'b0;
        load = 1'b0; load_val = 4'b0000;
        #2;
        step_chk("reset", 4'b0001, 1'b0, 1'b0);

        // Ring up
        init_n = 1'b1; en = 1'b1;
        step_chk("rup1", 4'b0010, 1'b0, 1'b0);
        step_chk("rup2", 4'b0100, 1'b0, 1'b0);
        step_chk("rup3", 4'b1000, 1'b0, 1'b0);
        step_chk("rup4", 4'b0001, 1'b1, 1'b0);

        // Ring down, then hold
        init_n = 1'b0;
        step_chk("rdn_rst", 4'b0001, 1'b0, 1'b0);
        init_n = 1'b1; dir = 1'b1;
        step_chk("rdn1", 4'b1000, 1'b0, 1'b0);
        step_chk("rdn2", 4'b0100, 1'b0, 1'b0);
        step_chk("rdn3", 4'b0010, 1'b0, 1'b0);
        step_chk("rdn4", 4'b0001, 1'b1, 1'b0);
        en = 1'b0;
        step_chk("hold1", 4'b0001, 1'b0, 1'b0);
        step_chk("hold2", 4'b0001, 1'b0, 1'b0);
        step_chk("hold3", 4'b0001, 1'b0, 1'b0);

        // Johnson up, full revolution, then down with wrap
        mode = 1'b1; dir = 1'b0; init_n = 1'b0;
        step_chk("jrst", 4'b0000, 1'b0, 1'b0);
        init_n = 1'b1; en = 1'b1;
        step_chk("jup1", 4'b0001, 1'b0, 1'b0);
        step_chk("jup2", 4'b0011, 1'b0, 1'b0);
        step_chk("jup3", 4'b0111, 1'b0, 1'b0);
        step_chk("jup4", 4'b1111, 1'b0, 1'b0);
        step_chk("jup5", 4'b1110, 1'b0, 1'b0);
        step_chk("jup6", 4'b1100, 1'b0, 1'b0);
        step_chk("jup7", 4'b1000, 1'b0, 1'b0);
        step_chk("jup8", 4'b0000, 1'b1, 1'b0);
        step_chk("jup9", 4'b0001, 1'b0, 1'b0);
        step_chk("jup10", 4'b0011, 1'b0, 1'b0);
        dir = 1'b1;
        step_chk("jdn1", 4'b0001, 1'b0, 1'b0);
        step_chk("jdn2", 4'b0000, 1'b1, 1'b0);

        // Ring-mode illegal load and correction
        mode = 1'b0; dir = 1'b0; en = 1'b0; init_n = 1'b0;
        step_chk("bad_rst", 4'b0001, 1'b0, 1'b0);
        init_n = 1'b1; load = 1'b1; load_val = 4'b0101;
        step_chk("bad_load", 4'b0101, 1'b0, 1'b0);
        load = 1'b0;
        step_chk("bad_fix", 4'b0001, 1'b0, 1'b1);
        step_chk("bad_after", 4'b0001, 1'b0, 1'b0);

        // Loading the home state does not raise wrap
        load = 1'b1; load_val = 4'b0001; en = 1'b1;
        step_chk("load_home", 4'b0001, 1'b0, 1'b0);
        load = 1'b0;

        // Mode switch: illegal under Johnson, then legal under both
        step_chk("ms_ring", 4'b0010, 1'b0, 1'b0);
        mode = 1'b1;
        step_chk("ms_fix", 4'b0000, 1'b0, 1'b1);
        mode = 1'b0; init_n = 1'b0;
        step_chk("ms_rst", 4'b0001, 1'b0, 1'b0);
        init_n = 1'b1; mode = 1'b1;
        step_chk("ms_both", 4'b0011, 1'b0, 1'b0);
        step_chk("ms_run", 4'b0111, 1'b0, 1'b0);

        // Reset outranks load and enable, in both modes
        init_n = 1'b0; load = 1'b1; load_val = 4'b1000;
        step_chk("prio_j", 4'b0000, 1'b0, 1'b0);
        mode = 1'b0;
        step_chk("prio_r", 4'b0001, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
